// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow, synchronous flush and an optional
// first-word-fall-through read port. DEPTH need not be a power of two.
//
// Handshake: a write is accepted when fifo_write=1 and the FIFO is not full,
// or when a read is accepted in the same cycle. A read is accepted when
// fifo_read=1 and the FIFO is not empty. There is no stall: a rejected request
// is dropped, only sets the sticky overflow/underflow flag, and changes no
// pointer, count or memory. fifo_clear blocks both requests in its cycle.
// In registered mode fifo_valid qualifies fifo_data_out for the one cycle
// after an accepted read. In FWFT mode fifo_valid means a head word is shown.
module fifo_sync_lvl #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_clear,
  input  logic                     fifo_write,
  input  logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     fifo_read,
  output logic [WIDTH-1:0]         fifo_data_out,
  output logic                     fifo_valid,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_almost_full,
  output logic                     fifo_almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_overflow,
  output logic                     fifo_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;
  logic             unf_q;
  logic             rd_acc;
  logic             wr_acc;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Status flags decode the registered count.
  assign fifo_empty        = (count == '0);
  assign fifo_full         = (count == DEPTH_C);
  assign fifo_almost_full  = (count >= AF_C);
  assign fifo_almost_empty = (count <= AE_C);
  assign fifo_count        = count;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = unf_q;

  // A read frees a slot at full, so a simultaneous write is still accepted.
  assign rd_acc = fifo_read && !fifo_empty && !fifo_clear;
  assign wr_acc = fifo_write && (!fifo_full || rd_acc) && !fifo_clear;

  // FWFT shows the head word directly; registered mode shows the captured word.
  assign fifo_data_out = (FWFT != 0) ? (fifo_empty ? '0 : mem[rd_ptr]) : data_q;
  assign fifo_valid    = (FWFT != 0) ? !fifo_empty : valid_q;

  // Storage write; the array itself is never reset or flushed.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  // Pointers, occupancy, registered read port and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst || fifo_clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
        data_q <= mem[rd_ptr];
      end
      valid_q <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (fifo_write && !wr_acc) begin
        ovf_q <= 1'b1;
      end
      if (fifo_read && fifo_empty) begin
        unf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Directed bench for fifo_sync_lvl: instance a uses the registered read port,
// instance b uses first-word-fall-through. Both are DEPTH=6, AF=4, AE=1.
module tb_fifo_sync_lvl;

  logic        clk;
  logic        rst;

  logic        clr_a, wr_a, rd_a;
  logic [15:0] din_a, dout_a;
  logic        vld_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [3:0]  cnt_a;

  logic        clr_b, wr_b, rd_b;
  logic [15:0] din_b, dout_b;
  logic        vld_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [3:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  fifo_sync_lvl #(.WIDTH(16), .DEPTH(6), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst), .fifo_clear(clr_a), .fifo_write(wr_a), .fifo_data_in(din_a),
    .fifo_read(rd_a), .fifo_data_out(dout_a), .fifo_valid(vld_a), .fifo_full(full_a),
    .fifo_empty(empty_a), .fifo_almost_full(af_a), .fifo_almost_empty(ae_a),
    .fifo_count(cnt_a), .fifo_overflow(ovf_a), .fifo_underflow(unf_a)
  );

  fifo_sync_lvl #(.WIDTH(16), .DEPTH(6), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst), .fifo_clear(clr_b), .fifo_write(wr_b), .fifo_data_in(din_b),
    .fifo_read(rd_b), .fifo_data_out(dout_b), .fifo_valid(vld_b), .fifo_full(full_b),
    .fifo_empty(empty_b), .fifo_almost_full(af_b), .fifo_almost_empty(ae_b),
    .fifo_count(cnt_b), .fifo_overflow(ovf_b), .fifo_underflow(unf_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle on instance a; outputs are stable #1 after the edge.
  task automatic step_a(input logic w, input logic [15:0] d, input logic r, input logic c);
    @(negedge clk);
    wr_a = w; din_a = d; rd_a = r; clr_a = c;
    @(posedge clk);
    #1;
    wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
  endtask

  // Drive one cycle on instance b.
  task automatic step_b(input logic w, input logic [15:0] d, input logic r);
    @(negedge clk);
    wr_b = w; din_b = d; rd_b = r;
    @(posedge clk);
    #1;
    wr_b = 1'b0; rd_b = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_a); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_a); end
    checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
    checks++; if (dout_a !== 16'h0000) begin errors++; $display("FAIL reset_dout got=%h exp=0000", dout_a); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vld_a); end
    checks++; if ({ovf_a, unf_a} !== 2'b00) begin errors++; $display("FAIL reset_sticky got=%b exp=00", {ovf_a, unf_a}); end
    checks++; if ({af_a, ae_a} !== 2'b01) begin errors++; $display("FAIL reset_almost got=%b exp=01", {af_a, ae_a}); end
    checks++; if ({vld_b, dout_b} !== 17'h0) begin errors++; $display("FAIL reset_fwft_out got=%h exp=0", {vld_b, dout_b}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 6; i++) begin
      step_a(1'b1, 16'(i), 1'b0, 1'b0);
      checks++; if (cnt_a !== 4'(i)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", cnt_a, i); end
      checks++; if (af_a !== (i >= 4)) begin errors++; $display("FAIL fill_af got=%b exp=%b at %0d", af_a, (i >= 4), i); end
      checks++; if (ae_a !== (i <= 1)) begin errors++; $display("FAIL fill_ae got=%b exp=%b at %0d", ae_a, (i <= 1), i); end
      checks++; if (full_a !== (i == 6)) begin errors++; $display("FAIL fill_full got=%b exp=%b at %0d", full_a, (i == 6), i); end
    end
    step_a(1'b1, 16'h0007, 1'b0, 1'b0);
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL overflow_flag got=%b exp=1", ovf_a); end
    checks++; if (cnt_a !== 4'd6) begin errors++; $display("FAIL overflow_count got=%0d exp=6", cnt_a); end
    for (int i = 1; i <= 6; i++) begin
      step_a(1'b0, 16'h0, 1'b1, 1'b0);
      checks++; if (dout_a !== 16'(i)) begin errors++; $display("FAIL drain_data got=%h exp=%h", dout_a, 16'(i)); end
      checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL drain_valid got=%b exp=1", vld_a); end
      checks++; if (cnt_a !== 4'(6 - i)) begin errors++; $display("FAIL drain_count got=%0d exp=%0d", cnt_a, 6 - i); end
    end
    step_a(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", vld_a); end
    checks++; if (dout_a !== 16'h0006) begin errors++; $display("FAIL idle_hold got=%h exp=0006", dout_a); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty_a); end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b exp=1", ovf_a); end
    step_a(1'b0, 16'h0, 1'b0, 1'b1);
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL clear_overflow got=%b exp=0", ovf_a); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) step_a(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step_a(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step_a(1'b1, 16'h00A0 + 16'(i), 1'b0, 1'b0);
    checks++; if (cnt_a !== 4'd5) begin errors++; $display("FAIL wrap_count got=%0d exp=5", cnt_a); end
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 16'h0, 1'b1, 1'b0);
      checks++; if (dout_a !== 16'h00A0 + 16'(i)) begin errors++; $display("FAIL wrap_data got=%h exp=%h", dout_a, 16'h00A0 + 16'(i)); end
      checks++; if (cnt_a !== 4'(4 - i)) begin errors++; $display("FAIL wrap_count_dn got=%0d exp=%0d", cnt_a, 4 - i); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step_a(1'b1, 16'h00B0 + 16'(i), 1'b0, 1'b0);
    step_a(1'b1, 16'h00B3, 1'b1, 1'b0);
    checks++; if (cnt_a !== 4'd3) begin errors++; $display("FAIL rw_mid_count got=%0d exp=3", cnt_a); end
    checks++; if (dout_a !== 16'h00B0) begin errors++; $display("FAIL rw_mid_data got=%h exp=00b0", dout_a); end
    for (int i = 4; i < 7; i++) step_a(1'b1, 16'h00B0 + 16'(i), 1'b0, 1'b0);
    checks++; if (full_a !== 1'b1) begin errors++; $display("FAIL rw_pre_full got=%b exp=1", full_a); end
    step_a(1'b1, 16'h00B7, 1'b1, 1'b0);
    checks++; if (cnt_a !== 4'd6) begin errors++; $display("FAIL rw_full_count got=%0d exp=6", cnt_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL rw_full_ovf got=%b exp=0", ovf_a); end
    checks++; if (dout_a !== 16'h00B1) begin errors++; $display("FAIL rw_full_data got=%h exp=00b1", dout_a); end
    for (int i = 2; i < 8; i++) begin
      step_a(1'b0, 16'h0, 1'b1, 1'b0);
      checks++; if (dout_a !== 16'h00B0 + 16'(i)) begin errors++; $display("FAIL rw_drain got=%h exp=%h", dout_a, 16'h00B0 + 16'(i)); end
    end
    step_a(1'b1, 16'h00C0, 1'b1, 1'b0);
    checks++; if (cnt_a !== 4'd1) begin errors++; $display("FAIL rw_empty_count got=%0d exp=1", cnt_a); end
    checks++; if (unf_a !== 1'b1) begin errors++; $display("FAIL rw_empty_unf got=%b exp=1", unf_a); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL rw_empty_valid got=%b exp=0", vld_a); end
    step_a(1'b0, 16'h0, 1'b1, 1'b0);
    checks++; if (dout_a !== 16'h00C0) begin errors++; $display("FAIL rw_empty_data got=%h exp=00c0", dout_a); end
    step_a(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_underflow_clear();
    step_a(1'b1, 16'h00D5, 1'b0, 1'b0);
    step_a(1'b0, 16'h0, 1'b1, 1'b0);
    checks++; if (dout_a !== 16'h00D5) begin errors++; $display("FAIL unf_setup_data got=%h exp=00d5", dout_a); end
    step_a(1'b0, 16'h0, 1'b1, 1'b0);
    checks++; if (unf_a !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", unf_a); end
    checks++; if (dout_a !== 16'h00D5) begin errors++; $display("FAIL unf_hold got=%h exp=00d5", dout_a); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL unf_valid got=%b exp=0", vld_a); end
    checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL unf_count got=%0d exp=0", cnt_a); end
    step_a(1'b0, 16'h0, 1'b0, 1'b1);
    checks++; if (unf_a !== 1'b0) begin errors++; $display("FAIL clear_unf got=%b exp=0", unf_a); end
    checks++; if (dout_a !== 16'h0000) begin errors++; $display("FAIL clear_dout got=%h exp=0000", dout_a); end
    step_a(1'b1, 16'h00E1, 1'b0, 1'b1);
    checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL clear_wr_count got=%0d exp=0", cnt_a); end
    checks++; if ({empty_a, ovf_a} !== 2'b10) begin errors++; $display("FAIL clear_wr_flags got=%b exp=10", {empty_a, ovf_a}); end
    step_a(1'b0, 16'h0, 1'b1, 1'b0);
    checks++; if (unf_a !== 1'b1) begin errors++; $display("FAIL clear_wr_dropped got=%b exp=1", unf_a); end
  endtask

  task automatic test_fwft();
    step_b(1'b1, 16'hABCD, 1'b0);
    checks++; if (dout_b !== 16'hABCD) begin errors++; $display("FAIL fwft_show got=%h exp=abcd", dout_b); end
    checks++; if (vld_b !== 1'b1) begin errors++; $display("FAIL fwft_valid got=%b exp=1", vld_b); end
    step_b(1'b1, 16'h1234, 1'b0);
    checks++; if (dout_b !== 16'hABCD) begin errors++; $display("FAIL fwft_head got=%h exp=abcd", dout_b); end
    step_b(1'b0, 16'h0, 1'b1);
    checks++; if (dout_b !== 16'h1234) begin errors++; $display("FAIL fwft_pop got=%h exp=1234", dout_b); end
    checks++; if (cnt_b !== 4'd1) begin errors++; $display("FAIL fwft_count got=%0d exp=1", cnt_b); end
    step_b(1'b0, 16'h0, 1'b1);
    checks++; if (empty_b !== 1'b1) begin errors++; $display("FAIL fwft_empty got=%b exp=1", empty_b); end
    checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL fwft_valid_drop got=%b exp=0", vld_b); end
    checks++; if (dout_b !== 16'h0000) begin errors++; $display("FAIL fwft_dout_zero got=%h exp=0000", dout_b); end
  endtask

  initial begin
    rst = 1'b0;
    clr_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0; din_a = '0;
    clr_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; din_b = '0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_underflow_clear();
    test_fwft();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
